// File: rtl/prod3_pkg.sv
// Shared types and constants for the program-3 product engine.
// The engine computes D = A * B * C on 8-bit signed operands into a 24-bit product.
package prod3_pkg;

    localparam int OPW       = 8;
    localparam int PW        = 24;
    localparam int MUL_ITERS = 8;

    typedef enum logic [3:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        MUL1,
        MUL2,
        FIX,
        WR0,
        WR1,
        WR2,
        DONE
    } state_t;

    // Unsigned magnitude of a two's-complement byte; -128 maps to 128.
    function automatic logic [OPW-1:0] mag8(input logic [OPW-1:0] v);
        return v[OPW-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/prod3_engine_seq_mult_u.sv
// Unsigned 16x8 shift-add multiplier with a 24-bit result.
// The load cycle performs the first partial product, so a result takes MUL_ITERS edges.
module seq_mult_u
    import prod3_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [15:0]   a,
    input  logic [OPW-1:0] b,
    output logic          busy,
    output logic          valid,
    output logic [PW-1:0] product
);

    localparam int CW = $clog2(MUL_ITERS);

    logic [PW-1:0]  acc;
    logic [PW-1:0]  mcand;
    logic [OPW-1:0] mplier;
    logic [CW-1:0]  cnt;

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else if (load) begin
            acc    <= b[0] ? PW'(a) : '0;
            mcand  <= PW'(a) << 1;
            mplier <= b >> 1;
            cnt    <= CW'(MUL_ITERS - 1);
            busy   <= 1'b1;
            valid  <= 1'b0;
        end else if (busy) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end else begin
            valid <= 1'b0;
        end
    end

    assign product = acc;

endmodule

// File: rtl/prod3_engine.sv
// Hardwired program-3 responder: reads three signed bytes from data memory,
// multiplies them, writes the 24-bit product back little-endian and raises done.
module prod3_engine
    import prod3_pkg::*;
#(
    parameter int OP_BASE  = 0,
    parameter int RES_BASE = 3,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    state_t         state, next_state;
    logic           start_q;
    logic           fall;
    logic [OPW-1:0] a_mag, b_mag, c_mag;
    logic           sign;
    logic [PW-1:0]  p;

    logic           mult_load;
    logic [15:0]    mult_a;
    logic [OPW-1:0] mult_b;
    logic           mult_busy;
    logic           mult_valid;
    logic [PW-1:0]  mult_product;

    logic           addr_upd;
    logic [AW-1:0]  addr_nxt;

    assign fall = start_q & ~start;

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fall) next_state = RD_A;
            RD_A:    next_state = RD_B;
            RD_B:    next_state = RD_C;
            RD_C:    next_state = MUL1;
            MUL1:    if (!mult_busy && mult_valid) next_state = MUL2;
            MUL2:    if (!mult_busy && mult_valid) next_state = FIX;
            FIX:     next_state = WR0;
            WR0:     next_state = WR1;
            WR1:     next_state = WR2;
            WR2:     next_state = DONE;
            DONE:    if (start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The multiplier is shared: first |A|*|B|, then that result times |C|.
    always_comb begin
        mult_load = 1'b0;
        mult_a    = mult_product[15:0];
        mult_b    = c_mag;
        if (state == RD_C) begin
            mult_load = 1'b1;
            mult_a    = 16'(a_mag);
            mult_b    = b_mag;
        end else if (state == MUL1 && next_state == MUL2) begin
            mult_load = 1'b1;
        end
    end

    // Address is registered on entry to each access state so it is valid for the
    // whole cycle of that state, and holds otherwise.
    always_comb begin
        addr_upd = 1'b1;
        addr_nxt = mem_addr;
        case (next_state)
            RD_A:    addr_nxt = AW'(OP_BASE);
            RD_B:    addr_nxt = AW'(OP_BASE + 1);
            RD_C:    addr_nxt = AW'(OP_BASE + 2);
            WR0:     addr_nxt = AW'(RES_BASE);
            WR1:     addr_nxt = AW'(RES_BASE + 1);
            WR2:     addr_nxt = AW'(RES_BASE + 2);
            default: addr_upd = 1'b0;
        endcase
        if (next_state == state)
            addr_upd = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            start_q  <= 1'b1;
            a_mag    <= '0;
            b_mag    <= '0;
            c_mag    <= '0;
            sign     <= 1'b0;
            p        <= '0;
            mem_addr <= '0;
        end else begin
            state   <= next_state;
            start_q <= start;
            case (state)
                RD_A: begin
                    a_mag <= mag8(mem_rd_data);
                    sign  <= mem_rd_data[7];
                end
                RD_B: begin
                    b_mag <= mag8(mem_rd_data);
                    sign  <= sign ^ mem_rd_data[7];
                end
                RD_C: begin
                    c_mag <= mag8(mem_rd_data);
                    sign  <= sign ^ mem_rd_data[7];
                end
                // Negating zero yields zero, so no special case is needed.
                FIX:     p <= sign ? (~mult_product + 1'b1) : mult_product;
                default: ;
            endcase
            if (addr_upd)
                mem_addr <= addr_nxt;
        end
    end

    always_comb begin
        done        = (state == DONE);
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            WR0: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = p[7:0];
            end
            WR1: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = p[15:8];
            end
            WR2: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = p[23:16];
            end
            default: ;
        endcase
    end

    seq_mult_u u_mult (
        .clk     (clk),
        .reset   (reset),
        .load    (mult_load),
        .a       (mult_a),
        .b       (mult_b),
        .busy    (mult_busy),
        .valid   (mult_valid),
        .product (mult_product)
    );

endmodule

// File: tb/tb_prod3_engine.sv
// Scoreboard bench for prod3_engine: behavioural data memory, expected products
// queued at each start fall and compared against memory when done rises.
module tb_prod3_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0]  mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          wr_count = 0;
    logic [23:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prod3_engine #(.OP_BASE(0), .RES_BASE(3), .AW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // One computation; pulse_at != 0 toggles start high for one edge mid-run.
    task automatic run_op(input int a, input int b, input int c, input int pulse_at,
                          input string name);
        int          cyc;
        int          wr0;
        int          prod;
        logic [23:0] e;
        poke(8'd0, 8'(a));
        poke(8'd1, 8'(b));
        poke(8'd2, 8'(c));
        prod = a * b * c;
        exp_q.push_back(24'(prod));
        wr0 = wr_count;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pulse_at != 0 && cyc == pulse_at)     start = 1'b1;
            if (pulse_at != 0 && cyc == pulse_at + 1) start = 1'b0;
        end
        // cyc counts edge N as 1, so done first seen at edge N+23 gives 24.
        check({name, "_latency"}, cyc, 24);
        e = exp_q.pop_front();
        check({name, "_result"}, {8'h0, mem[5], mem[4], mem[3]}, {8'h0, e});
        check({name, "_writes"}, wr_count - wr0, 3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_done_drop"}, done, 0);
    endtask

    initial begin
        int done_seen;
        int wr0;
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op(2, 4, 8, 0, "basic");
        run_op(-128, -128, -128, 0, "min_neg");
        run_op(127, 127, 127, 0, "max_pos");
        run_op(-1, 1, 1, 0, "minus_one");
        run_op(-5, 0, 7, 0, "neg_zero");

        // Abort with reset at fall+10.
        poke(8'd0, 8'd9);
        poke(8'd1, 8'd9);
        poke(8'd2, 8'd9);
        poke(8'd3, 8'hAA);
        poke(8'd4, 8'hBB);
        poke(8'd5, 8'hCC);
        wr0 = wr_count;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_done", done_seen, 0);
        check("abort_mem", {8'h0, mem[5], mem[4], mem[3]}, 32'h00CCBBAA);
        check("abort_writes", wr_count - wr0, 0);

        run_op(6, -7, 3, 0, "after_abort");
        run_op(3, -2, 5, 5, "ignored_pulse");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
